// File: rtl/idex_hazard_unit.sv
// -----------------------------------------------------------------------------
// idex_hazard_unit
//
// Hazard and forwarding controller on the read side of the ID/EX pipeline
// register. It keeps a shadow of {valid, rd, load} for the instructions now in
// EX, MEM and WB. From that shadow and the operands of the ID instruction it
// computes:
//   - the forwarding selects for operand ports A, B and C
//   - the load-use stall
//   - the branch flush
//   - the memory-busy freeze
// All outputs are combinational in the current cycle, so they take effect with
// no added latency.
//
// Parameters
//   LOAD_LATENCY : stages after EX before load data can be forwarded (1 or 2)
//   PC_REG       : register number that never hazards and is never forwarded
//
// Ports
//   CLK            pipeline clock
//   CLR            synchronous active-high reset
//   ID_Rn/Rm/Rs    source registers of ports A/B/C in ID
//   ID_Use[2:0]    per-port use flags (bit0=A, bit1=B, bit2=C)
//   ID_rf, ID_Rd   ID instruction writes register ID_Rd
//   ID_Load        ID instruction is a load
//   Branch_Taken   branch resolved taken in EX this cycle
//   Mem_Busy       data memory not ready; freeze the whole pipeline
//   PC_LE          PC load enable
//   IFID_LE        IF/ID load enable
//   IFID_CLR       IF/ID clear
//   IDEX_CLR       ID/EX clear (bubble insert)
//   Fwd_A/B/C      operand select: 00 regfile, 01 EX, 10 MEM, 11 WB
//
// Optional build macro
//   IDEX_HAZARD_PERF_CNT_EN : adds Stall_Count / Flush_Count outputs, 16-bit
//   saturating counters of STALL and FLUSH cycles. They clear on CLR and
//   hold while frozen. With the macro undefined, the ports and counters are
//   absent.
//
// Cycle mode (decided combinationally each cycle, priority top to bottom)
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_FREEZE | Mem_Busy: all enables low, slots hold, branch ignored
//   ST_FLUSH  | branch taken: clear IF/ID and ID/EX, EX slot gets a bubble
//   ST_STALL  | load-use: hold PC and IF/ID, bubble into EX, MEM/WB shift
//   ST_RUN    | normal advance, ID instruction enters the EX slot
// -----------------------------------------------------------------------------
module idex_hazard_unit #(
  parameter int         LOAD_LATENCY = 1,
  parameter logic [3:0] PC_REG       = 4'd15
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic [3:0]  ID_Rn,
  input  logic [3:0]  ID_Rm,
  input  logic [3:0]  ID_Rs,
  input  logic [2:0]  ID_Use,
  input  logic        ID_rf,
  input  logic [3:0]  ID_Rd,
  input  logic        ID_Load,
  input  logic        Branch_Taken,
  input  logic        Mem_Busy,
  output logic        PC_LE,
  output logic        IFID_LE,
  output logic        IFID_CLR,
  output logic        IDEX_CLR,
  output logic [1:0]  Fwd_A,
  output logic [1:0]  Fwd_B,
  output logic [1:0]  Fwd_C
`ifdef IDEX_HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] Stall_Count,
  output logic [15:0] Flush_Count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_FREEZE = 2'd3
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  // A load sitting in MEM can only forward when the data is already there,
  // i.e. when the load latency is a single stage.
  localparam bit MEM_LOAD_BLOCKED = (LOAD_LATENCY > 1);

  // ---------------------------------------------------------------------------
  // Shadow slots for EX, MEM and WB
  // ---------------------------------------------------------------------------
  logic       ex_v,  mem_v,  wb_v;
  logic [3:0] ex_rd, mem_rd, wb_rd;
  logic       ex_ld, mem_ld, wb_ld;

  state_t     state;
  logic       load_use;
  logic [3:0] src     [3];
  logic [1:0] fwd_sel [3];

  assign src[0] = ID_Rn;
  assign src[1] = ID_Rm;
  assign src[2] = ID_Rs;

  // ---------------------------------------------------------------------------
  // Hazard resolution. Each port looks for the youngest matching producer.
  // A younger match always shadows older ones, so a load in EX blocks the
  // port even when MEM or WB also hold the register.
  // ---------------------------------------------------------------------------
  always_comb begin
    load_use = 1'b0;
    for (int p = 0; p < 3; p++) begin
      fwd_sel[p] = FWD_RF;
      if (ID_Use[p] && (src[p] != PC_REG)) begin
        if (ex_v && (ex_rd == src[p])) begin
          if (ex_ld) begin
            load_use = 1'b1;
          end else begin
            fwd_sel[p] = FWD_EX;
          end
        end else if (mem_v && (mem_rd == src[p])) begin
          if (mem_ld && MEM_LOAD_BLOCKED) begin
            load_use = 1'b1;
          end else begin
            fwd_sel[p] = FWD_MEM;
          end
        end else if (wb_v && (wb_rd == src[p])) begin
          fwd_sel[p] = FWD_WB;
        end
      end
    end
  end

  assign Fwd_A = fwd_sel[0];
  assign Fwd_B = fwd_sel[1];
  assign Fwd_C = fwd_sel[2];

  // ---------------------------------------------------------------------------
  // Mode selection (next-state logic). The mode is re-evaluated every cycle;
  // a multi-cycle stall falls out naturally as the load walks through MEM.
  // ---------------------------------------------------------------------------
  always_comb begin
    state = ST_RUN;
    if (Mem_Busy) begin
      state = ST_FREEZE;
    end else if (Branch_Taken) begin
      state = ST_FLUSH;
    end else if (load_use) begin
      state = ST_STALL;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    PC_LE    = 1'b1;
    IFID_LE  = 1'b1;
    IFID_CLR = 1'b0;
    IDEX_CLR = 1'b0;
    case (state)
      ST_FREEZE: begin
        PC_LE   = 1'b0;
        IFID_LE = 1'b0;
      end
      ST_FLUSH: begin
        IFID_CLR = 1'b1;
        IDEX_CLR = 1'b1;
      end
      ST_STALL: begin
        PC_LE    = 1'b0;
        IFID_LE  = 1'b0;
        IDEX_CLR = 1'b1;
      end
      default: begin
        PC_LE   = 1'b1;
        IFID_LE = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Slot register. FREEZE holds everything; otherwise the slots shift and EX
  // takes either the ID instruction (RUN) or a bubble (STALL / FLUSH).
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (CLR) begin
      ex_v   <= 1'b0;
      ex_rd  <= 4'd0;
      ex_ld  <= 1'b0;
      mem_v  <= 1'b0;
      mem_rd <= 4'd0;
      mem_ld <= 1'b0;
      wb_v   <= 1'b0;
      wb_rd  <= 4'd0;
      wb_ld  <= 1'b0;
    end else if (state != ST_FREEZE) begin
      wb_v   <= mem_v;
      wb_rd  <= mem_rd;
      wb_ld  <= mem_ld;
      mem_v  <= ex_v;
      mem_rd <= ex_rd;
      mem_ld <= ex_ld;
      if (state == ST_RUN) begin
        ex_v  <= ID_rf;
        ex_rd <= ID_Rd;
        ex_ld <= ID_Load;
      end else begin
        ex_v  <= 1'b0;
        ex_rd <= 4'd0;
        ex_ld <= 1'b0;
      end
    end
  end

`ifdef IDEX_HAZARD_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters; frozen cycles are neither STALL nor
  // FLUSH, so the counters hold through them.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (CLR) begin
      Stall_Count <= 16'd0;
      Flush_Count <= 16'd0;
    end else begin
      if ((state == ST_STALL) && (Stall_Count != 16'hFFFF)) begin
        Stall_Count <= Stall_Count + 16'd1;
      end
      if ((state == ST_FLUSH) && (Flush_Count != 16'hFFFF)) begin
        Flush_Count <= Flush_Count + 16'd1;
      end
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_idex_hazard_unit.sv
// Self-checking bench for idex_hazard_unit. Two instances are driven in
// parallel with identical inputs, one per legal LOAD_LATENCY. A reference
// model keeps the in-flight instructions as a short age-ordered list and
// resolves each operand by searching that list from youngest to oldest.
module tb_idex_hazard_unit;

  logic       CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       CLR, Mem_Busy, Branch_Taken, ID_rf, ID_Load;
  logic [3:0] ID_Rn, ID_Rm, ID_Rs, ID_Rd;
  logic [2:0] ID_Use;

  logic       pc_le0, ifid_le0, ifid_clr0, idex_clr0;
  logic       pc_le1, ifid_le1, ifid_clr1, idex_clr1;
  logic [1:0] fa0, fb0, fc0, fa1, fb1, fc1;
`ifdef IDEX_HAZARD_PERF_CNT_EN
  logic [15:0] scnt0, fcnt0, scnt1, fcnt1;
`endif

  idex_hazard_unit #(.LOAD_LATENCY(1), .PC_REG(4'd15)) dut_ll1 (
    .CLK(CLK), .CLR(CLR), .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rs(ID_Rs),
    .ID_Use(ID_Use), .ID_rf(ID_rf), .ID_Rd(ID_Rd), .ID_Load(ID_Load),
    .Branch_Taken(Branch_Taken), .Mem_Busy(Mem_Busy),
    .PC_LE(pc_le0), .IFID_LE(ifid_le0), .IFID_CLR(ifid_clr0), .IDEX_CLR(idex_clr0),
    .Fwd_A(fa0), .Fwd_B(fb0), .Fwd_C(fc0)
`ifdef IDEX_HAZARD_PERF_CNT_EN
    , .Stall_Count(scnt0), .Flush_Count(fcnt0)
`endif
  );

  idex_hazard_unit #(.LOAD_LATENCY(2), .PC_REG(4'd15)) dut_ll2 (
    .CLK(CLK), .CLR(CLR), .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rs(ID_Rs),
    .ID_Use(ID_Use), .ID_rf(ID_rf), .ID_Rd(ID_Rd), .ID_Load(ID_Load),
    .Branch_Taken(Branch_Taken), .Mem_Busy(Mem_Busy),
    .PC_LE(pc_le1), .IFID_LE(ifid_le1), .IFID_CLR(ifid_clr1), .IDEX_CLR(idex_clr1),
    .Fwd_A(fa1), .Fwd_B(fb1), .Fwd_C(fc1)
`ifdef IDEX_HAZARD_PERF_CNT_EN
    , .Stall_Count(scnt1), .Flush_Count(fcnt1)
`endif
  );

  localparam logic [1:0] M_RUN = 2'd0, M_STALL = 2'd1, M_FLUSH = 2'd2, M_FREEZE = 2'd3;

  typedef struct packed {
    logic       v;
    logic [3:0] rd;
    logic       ld;
  } slot_t;

  typedef struct packed {
    logic [3:0]  ctl;   // {PC_LE, IFID_LE, IFID_CLR, IDEX_CLR}
    logic [5:0]  fwd;   // {C, B, A}
    logic [2:0]  care;  // port select is meaningful (not waiting on a load)
    logic [1:0]  mode;
    logic [15:0] scnt;
    logic [15:0] fcnt;
  } exp_t;

  // pipe[d][age]: age 0 = EX, 1 = MEM, 2 = WB
  slot_t       pipe [2][3];
  logic [15:0] m_scnt [2];
  logic [15:0] m_fcnt [2];
  exp_t        q0[$];
  exp_t        q1[$];
  int          checks   = 0;
  int          failures = 0;

  function automatic exp_t predict(input int d, input logic mb, input logic bt,
                                   input logic [2:0] use_f, input logic [3:0] rn,
                                   input logic [3:0] rm, input logic [3:0] rs);
    exp_t       e;
    logic [3:0] src [3];
    logic [1:0] sel;
    logic       blk;
    logic       lu;
    int         ll;
    ll     = (d == 0) ? 1 : 2;
    src[0] = rn;
    src[1] = rm;
    src[2] = rs;
    lu     = 1'b0;
    e      = '0;
    for (int p = 0; p < 3; p++) begin
      sel = 2'b00;
      blk = 1'b0;
      if (use_f[p] && src[p] != 4'd15) begin
        for (int a = 0; a < 3; a++) begin
          if (pipe[d][a].v && pipe[d][a].rd == src[p]) begin
            if (pipe[d][a].ld && a < ll) blk = 1'b1;
            else sel = 2'(a + 1);
            break;
          end
        end
      end
      e.fwd[2*p +: 2] = sel;
      e.care[p]       = ~blk;
      lu              = lu | blk;
    end
    if (mb)      e.mode = M_FREEZE;
    else if (bt) e.mode = M_FLUSH;
    else if (lu) e.mode = M_STALL;
    else         e.mode = M_RUN;
    case (e.mode)
      M_FREEZE: e.ctl = 4'b0000;
      M_FLUSH:  e.ctl = 4'b1111;
      M_STALL:  e.ctl = 4'b0001;
      default:  e.ctl = 4'b1100;
    endcase
    e.scnt = m_scnt[d];
    e.fcnt = m_fcnt[d];
    return e;
  endfunction

  task automatic advance(input int d, input exp_t e, input logic clr,
                         input logic rf, input logic [3:0] rd, input logic ld);
    if (clr) begin
      for (int a = 0; a < 3; a++) pipe[d][a] = '0;
      m_scnt[d] = 16'd0;
      m_fcnt[d] = 16'd0;
    end else if (e.mode != M_FREEZE) begin
      pipe[d][2] = pipe[d][1];
      pipe[d][1] = pipe[d][0];
      pipe[d][0] = (e.mode == M_RUN && rf) ? slot_t'({1'b1, rd, ld}) : slot_t'(6'd0);
      if (e.mode == M_STALL && m_scnt[d] != 16'hFFFF) m_scnt[d] = m_scnt[d] + 16'd1;
      if (e.mode == M_FLUSH && m_fcnt[d] != 16'hFFFF) m_fcnt[d] = m_fcnt[d] + 16'd1;
    end
  endtask

  task automatic chk(input string name, input int d, input logic [15:0] got,
                     input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s ll%0d got=%0h want=%0h at %0t", name, d + 1, got, want, $time);
    end
  endtask

  task automatic compare(input int d, input exp_t e);
    logic [3:0] ctl;
    logic [5:0] fwd;
    if (d == 0) begin
      ctl = {pc_le0, ifid_le0, ifid_clr0, idex_clr0};
      fwd = {fc0, fb0, fa0};
    end else begin
      ctl = {pc_le1, ifid_le1, ifid_clr1, idex_clr1};
      fwd = {fc1, fb1, fa1};
    end
    chk("ctl", d, {12'd0, ctl}, {12'd0, e.ctl});
    if (e.care[0]) chk("fwd_a", d, {14'd0, fwd[1:0]}, {14'd0, e.fwd[1:0]});
    if (e.care[1]) chk("fwd_b", d, {14'd0, fwd[3:2]}, {14'd0, e.fwd[3:2]});
    if (e.care[2]) chk("fwd_c", d, {14'd0, fwd[5:4]}, {14'd0, e.fwd[5:4]});
`ifdef IDEX_HAZARD_PERF_CNT_EN
    chk("stall_cnt", d, (d == 0) ? scnt0 : scnt1, e.scnt);
    chk("flush_cnt", d, (d == 0) ? fcnt0 : fcnt1, e.fcnt);
`endif
  endtask

  // Monitor: one response per instance is due every cycle the stimulus queued one.
  always @(negedge CLK) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      compare(0, e);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      compare(1, e);
    end
  end

  task automatic step(input logic clr, input logic mb, input logic bt,
                      input logic rf, input logic [3:0] rd, input logic ld,
                      input logic [2:0] use_f, input logic [3:0] rn,
                      input logic [3:0] rm, input logic [3:0] rs, input bit push);
    exp_t e0, e1;
    CLR = clr; Mem_Busy = mb; Branch_Taken = bt;
    ID_rf = rf; ID_Rd = rd; ID_Load = ld;
    ID_Use = use_f; ID_Rn = rn; ID_Rm = rm; ID_Rs = rs;
    e0 = predict(0, mb, bt, use_f, rn, rm, rs);
    e1 = predict(1, mb, bt, use_f, rn, rm, rs);
    if (push) begin
      q0.push_back(e0);
      q1.push_back(e1);
    end
    @(posedge CLK);
    advance(0, e0, clr, rf, rd, ld);
    advance(1, e1, clr, rf, rd, ld);
    #1;
  endtask

  task automatic op(input logic rf, input logic [3:0] rd, input logic ld,
                    input logic [2:0] use_f, input logic [3:0] rn,
                    input logic [3:0] rm, input logic [3:0] rs);
    step(1'b0, 1'b0, 1'b0, rf, rd, ld, use_f, rn, rm, rs, 1'b1);
  endtask

  function automatic logic [3:0] rreg();
    int r;
    r = $urandom_range(0, 6);
    return (r == 6) ? 4'd15 : 4'(r);
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 3; a++) pipe[d][a] = '0;
      m_scnt[d] = 16'd0;
      m_fcnt[d] = 16'd0;
    end
    CLR = 1'b1; Mem_Busy = 1'b0; Branch_Taken = 1'b0;
    ID_rf = 1'b0; ID_Rd = 4'd0; ID_Load = 1'b0;
    ID_Use = 3'b000; ID_Rn = 4'd0; ID_Rm = 4'd0; ID_Rs = 4'd0;
    @(posedge CLK);
    #1;

    // Reset: first cycle has unknown slots, second shows the cleared state.
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'b111, 4'd3, 4'd5, 4'd2, 1'b1);

    // ALU result forwarded from EX, then MEM.
    op(1'b1, 4'd3, 1'b0, 3'b000, 4'd0, 4'd0, 4'd0);
    op(1'b0, 4'd0, 1'b0, 3'b001, 4'd3, 4'd0, 4'd0);
    op(1'b0, 4'd0, 1'b0, 3'b001, 4'd3, 4'd0, 4'd0);

    // Load-use on port B; the consumer is held in ID while stalled.
    op(1'b1, 4'd5, 1'b1, 3'b000, 4'd0, 4'd0, 4'd0);
    op(1'b0, 4'd0, 1'b0, 3'b010, 4'd0, 4'd5, 4'd0);
    op(1'b0, 4'd0, 1'b0, 3'b010, 4'd0, 4'd5, 4'd0);
    op(1'b0, 4'd0, 1'b0, 3'b010, 4'd0, 4'd5, 4'd0);

    // Load-use coinciding with a taken branch: flush wins.
    op(1'b1, 4'd5, 1'b1, 3'b000, 4'd0, 4'd0, 4'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 3'b010, 4'd0, 4'd5, 4'd0, 1'b1);
    op(1'b0, 4'd0, 1'b0, 3'b000, 4'd0, 4'd0, 4'd0);

    // Freeze with R2 in EX, then read R2 after release.
    op(1'b1, 4'd2, 1'b0, 3'b000, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 3'b001, 4'd2, 4'd0, 4'd0, 1'b1);
    op(1'b0, 4'd0, 1'b0, 3'b001, 4'd2, 4'd0, 4'd0);

    // PC register never forwards or stalls, even as a load destination.
    op(1'b1, 4'd15, 1'b1, 3'b000, 4'd0, 4'd0, 4'd0);
    op(1'b0, 4'd0, 1'b0, 3'b111, 4'd15, 4'd15, 4'd15);

    // All three ports hitting the same slot.
    op(1'b1, 4'd7, 1'b0, 3'b000, 4'd0, 4'd0, 4'd0);
    op(1'b0, 4'd0, 1'b0, 3'b111, 4'd7, 4'd7, 4'd7);

    // CLR during a stall, then during a freeze.
    op(1'b1, 4'd4, 1'b1, 3'b000, 4'd0, 4'd0, 4'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'b001, 4'd4, 4'd0, 4'd0, 1'b1);
    op(1'b0, 4'd0, 1'b0, 3'b001, 4'd4, 4'd0, 4'd0);
    op(1'b1, 4'd6, 1'b0, 3'b000, 4'd0, 4'd0, 4'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 3'b001, 4'd6, 4'd0, 4'd0, 1'b1);
    op(1'b0, 4'd0, 1'b0, 3'b001, 4'd6, 4'd0, 4'd0);

    // Randomized traffic over a small register set to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 59) == 0),
           1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 11) == 0),
           1'($urandom_range(0, 3) != 0),
           rreg(),
           1'($urandom_range(0, 2) == 0),
           3'($urandom_range(0, 7)),
           rreg(), rreg(), rreg(), 1'b1);
    end

    @(negedge CLK);
    #1;
    chk("drain_q0", 0, 16'(q0.size()), 16'd0);
    chk("drain_q1", 1, 16'(q1.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/idex_hazard_unit.md
Name: idex_hazard_unit

Overview:
- Hazard and forwarding controller on the read side of the ID/EX pipeline register.
- Keeps its own shadow copy of the destination register, register-write flag and load flag for the instructions in EX, MEM and WB.
- Produces forwarding selects for register-file mux ports A/B/C, the load-use stall, the branch flush and the memory-busy freeze.
- Drives the PC and IF/ID load enables and the IF/ID and ID/EX CLR inputs.

Parameters:
- LOAD_LATENCY, 1: number of stages after EX before load data can be forwarded. Legal values 1 or 2.
- PC_REG, 15: register number that never creates a hazard and is never forwarded.

Ports:
- CLK  in  1  pipeline clock
- CLR  in  1  synchronous active-high reset
- ID_Rn  in  4  port A source register in ID
- ID_Rm  in  4  port B source register in ID
- ID_Rs  in  4  port C source register in ID (store data / shift register)
- ID_Use  in  3  per-port use flags: bit0=A, bit1=B, bit2=C
- ID_rf  in  1  ID instruction writes the register file
- ID_Rd  in  4  ID destination register
- ID_Load  in  1  ID instruction is a load
- Branch_Taken  in  1  branch resolved taken in EX this cycle
- Mem_Busy  in  1  data memory not ready; freeze the whole pipeline
- PC_LE  out  1  PC load enable
- IFID_LE  out  1  IF/ID load enable
- IFID_CLR  out  1  IF/ID clear
- IDEX_CLR  out  1  ID/EX clear (bubble insert)
- Fwd_A  out  2  port A select: 00 regfile, 01 EX, 10 MEM, 11 WB
- Fwd_B  out  2  port B select, same encoding
- Fwd_C  out  2  port C select, same encoding

Behaviour:
- Slots: EX, MEM and WB, each holding {v, rd[3:0], ld}.
- Reset: when CLR=1 at a CLK edge, all slots get v=0 and the FSM goes to RUN. With all slots invalid the outputs are Fwd_*=00, PC_LE=1, IFID_LE=1, IFID_CLR=0, IDEX_CLR=0.
- A match on port X requires all of:
  - ID_Use[X]=1
  - the source register is not PC_REG
  - slot.v=1 and slot.rd equals the source register
- Forward priority per port: EX > MEM > WB. If nothing matches, the select is 00.
- A slot with ld=1 can only forward once it is at least LOAD_LATENCY stages past EX:
  - LOAD_LATENCY=1: load data forwards from MEM or WB.
  - LOAD_LATENCY=2: load data forwards from WB only.
- load_use: asserted when the highest-priority match on any port is a load slot that cannot forward yet.
- Fwd_* and all control outputs are combinational from the slots, the ID inputs and the FSM state. Latency 0.

FSM states and priority:
- FREEZE: Mem_Busy=1. Highest priority.
  - PC_LE=0, IFID_LE=0, IFID_CLR=0, IDEX_CLR=0.
  - Slots hold their values. Branch_Taken is ignored.
  - On Mem_Busy=0, return to RUN.
- FLUSH: Branch_Taken=1 and Mem_Busy=0.
  - IFID_CLR=1, IDEX_CLR=1, PC_LE=1. Lasts one cycle.
  - The EX slot loads a bubble (v=0).
  - Flush overrides load_use: the stall is dropped.
- STALL: load_use=1 with no flush and no freeze.
  - PC_LE=0, IFID_LE=0, IDEX_CLR=1.
  - The EX slot loads a bubble; MEM and WB shift normally.
  - Re-evaluated every cycle. With LOAD_LATENCY=2 the stall lasts 2 cycles.
- RUN: all load enables 1, all clears 0.

Slot shift (every cycle except FREEZE):
- WB <= MEM, MEM <= EX.
- EX <= {ID_rf, ID_Rd, ID_Load} in RUN; v=0 in STALL or FLUSH.
- A slot with ID_rf=0 is stored invalid.

Boundary conditions:
- Several ports matching the same slot is legal; each port is selected independently.
- CLR asserted mid-stall or mid-freeze: at the next edge the FSM goes to RUN and all slots are cleared.
- Rd equal to PC_REG in a slot never causes forwarding or a stall.

Optional Feature:
- Macro: IDEX_HAZARD_PERF_CNT_EN
- Defined:
  - Extra output Stall_Count [15:0]: increments on each STALL cycle.
  - Extra output Flush_Count [15:0]: increments on each FLUSH cycle.
  - Both saturate at 16'hFFFF, reset to 0 on CLR, and hold during FREEZE.
- Undefined: neither port exists and there is no counter logic.

Test Plan:
- CLR=1 for 2 cycles -> Fwd_A/B/C=00, PC_LE=1, IFID_LE=1, IFID_CLR=0, IDEX_CLR=0.
- ADD R3 (rf=1, load=0), then the next instruction reads Rn=R3 on port A -> Fwd_A=01 that cycle, no stall. One cycle later the same read gives Fwd_A=10.
- LDR R5 (LOAD_LATENCY=1), then the next instruction uses Rm=R5 on port B:
  - cycle 1: PC_LE=0, IFID_LE=0, IDEX_CLR=1
  - cycle 2: Fwd_B=10, no stall
  - Repeat with LOAD_LATENCY=2: two stall cycles, then Fwd_B=11.
- Load-use on R5 and Branch_Taken=1 in the same cycle -> IFID_CLR=1, IDEX_CLR=1, PC_LE=1, no stall. With the macro defined, Flush_Count=1 and Stall_Count=0.
- Mem_Busy=1 for 3 cycles while an EX slot holds R2 -> PC_LE=0, IFID_LE=0, slots unchanged. After release, an ID read of R2 gives Fwd=01.
- ID reads R15 while the EX slot has rd=15 -> Fwd=00, no stall.
